// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX transmit packer.
// Word lanes are numbered from the MSB: lane 0 is [63:56].
package fix_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 64;
    localparam int LANES  = WORD_W / BYTE_W;

    localparam logic [BYTE_W-1:0] SOH = 8'h01;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        DROP
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [2:0]        empty;
        logic              err;
    } word_t;

endpackage

// File: rtl/fix_tx_packer_if.sv
// Byte-FIFO read side and packet-stream side of the FIX transmit packer.
// The master modport is the packer; the slave modport is its environment.
interface fix_tx_packer_if #(
    parameter int CNT_W = 16
);
    logic             rd_empty_i;
    logic [7:0]       rd_data_i;
    logic             rd_eom_i;
    logic             rd_error_i;
    logic             readreq_o;
    logic             start_pkt_o;
    logic             end_pkt_o;
    logic             valid_o;
    logic             ready_i;
    logic [63:0]      packet_o;
    logic [2:0]       empty_o;
    logic             error_o;
    logic [CNT_W-1:0] msg_count_o;

    modport master (
        input  rd_empty_i, rd_data_i, rd_eom_i, rd_error_i,
        input  ready_i,
        output readreq_o, start_pkt_o, end_pkt_o, valid_o,
        output packet_o, empty_o, error_o, msg_count_o
    );

    modport slave (
        output rd_empty_i, rd_data_i, rd_eom_i, rd_error_i,
        output ready_i,
        input  readreq_o, start_pkt_o, end_pkt_o, valid_o,
        input  packet_o, empty_o, error_o, msg_count_o
    );

endinterface

// File: rtl/fix_st_out_reg.sv
// Output stage: one word with valid/ready, held stable while stalled.
module fix_st_out_reg
    import fix_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  word_t i_word,
    input  logic  i_ready,
    output logic  o_valid,
    output word_t o_word,
    output logic  o_can_load
);

    logic  r_valid;
    word_t r_word;

    assign o_can_load = ~r_valid | i_ready;
    assign o_valid    = r_valid;
    assign o_word     = r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fix_tx_packer.sv
// Packs FIX message bytes from a read-latency-1 FIFO into 64-bit words,
// truncating over-long messages and flagging FIFO errors per packet.
module fix_tx_packer
    import fix_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 1024,
    parameter int CNT_W         = 16
) (
    input logic             clk,
    input logic             rst,
    fix_tx_packer_if.master bus
);

    localparam int BC_W = $clog2(MAX_MSG_BYTES + 1);

    state_t            r_state, w_state_nx;
    logic              r_live, r_pend;
    logic              r_skid_v, r_skid_eom;
    byte_t             r_skid_d;
    logic [WORD_W-1:0] r_asm_data, w_asm_nx;
    logic [2:0]        r_lane, r_asm_empty;
    logic              r_asm_done, r_asm_sop;
    logic              r_asm_eop, r_asm_err;
    logic [BC_W-1:0]   r_bcnt, w_cnt;
    logic              r_err, w_err_now;
    logic [CNT_W-1:0]  r_msg_cnt;
    logic              w_bv, w_eom, w_first;
    byte_t             w_b;
    logic              w_can_load, w_move, w_room;
    logic              w_take, w_rdreq, w_valid;
    logic              w_wr, w_end, w_trunc, w_cmp;
    word_t             w_word_in, w_out;

    // The skid byte always has priority over the FIFO return path.
    assign w_bv      = r_skid_v | r_pend;
    assign w_b       = r_skid_v ? r_skid_d : bus.rd_data_i;
    assign w_eom     = r_skid_v ? r_skid_eom : bus.rd_eom_i;
    assign w_move    = r_asm_done & w_can_load;
    assign w_room    = ~r_asm_done | w_move;
    assign w_take    = w_bv & ((r_state == DROP) | w_room);
    assign w_rdreq   = r_live & ~bus.rd_empty_i & ~r_skid_v & w_room;
    assign w_first   = (r_state == IDLE);
    assign w_cnt     = w_first ? BC_W'(1) : r_bcnt + BC_W'(1);
    assign w_err_now = r_err | ((r_state == BODY) & bus.rd_error_i);

    always_comb begin
        w_state_nx = r_state;
        w_wr       = 1'b0;
        w_end      = 1'b0;
        w_trunc    = 1'b0;
        w_cmp      = 1'b0;
        w_asm_nx   = (r_lane == 3'd0) ? '0 : r_asm_data;
        w_asm_nx[(7 - int'(r_lane)) * 8 +: 8] = w_b;
        unique case (r_state)
            IDLE, BODY: begin
                if (w_take) begin
                    w_wr       = 1'b1;
                    w_end      = w_eom | (w_cnt == BC_W'(MAX_MSG_BYTES));
                    w_trunc    = w_end & ~w_eom;
                    w_cmp      = w_end | (r_lane == 3'd7);
                    w_state_nx = w_eom ? IDLE : (w_trunc ? DROP : BODY);
                end
            end
            DROP: begin
                if (w_take & w_eom) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live      <= 1'b0;
            r_pend      <= 1'b0;
            r_skid_v    <= 1'b0;
            r_skid_d    <= '0;
            r_skid_eom  <= 1'b0;
            r_asm_data  <= '0;
            r_lane      <= '0;
            r_asm_done  <= 1'b0;
            r_asm_sop   <= 1'b0;
            r_asm_eop   <= 1'b0;
            r_asm_err   <= 1'b0;
            r_asm_empty <= '0;
            r_bcnt      <= '0;
            r_err       <= 1'b0;
            r_msg_cnt   <= '0;
        end else begin
            r_live <= 1'b1;
            r_pend <= w_rdreq;
            if (w_take & r_skid_v) begin
                r_skid_v <= 1'b0;
            end else if (r_pend & ~w_take) begin
                r_skid_v   <= 1'b1;
                r_skid_d   <= bus.rd_data_i;
                r_skid_eom <= bus.rd_eom_i;
            end
            if (w_wr) begin
                r_asm_data <= w_asm_nx;
                r_lane     <= w_cmp ? 3'd0 : r_lane + 3'd1;
                r_bcnt     <= w_cnt;
                if (r_lane == 3'd0) r_asm_sop <= w_first;
                if (w_cmp) begin
                    r_asm_eop   <= w_end;
                    r_asm_err   <= w_end & (w_err_now | w_trunc);
                    r_asm_empty <= 3'd7 - r_lane;
                end
            end
            r_asm_done <= w_wr ? w_cmp : (r_asm_done & ~w_move);
            // The end word carries the error away; the next packet starts clean.
            r_err <= (w_wr & w_end) ? 1'b0 : w_err_now;
            if (w_valid & bus.ready_i & w_out.eop)
                r_msg_cnt <= r_msg_cnt + 1'b1;
        end
    end

    assign w_word_in = '{
        data:  r_asm_data,
        sop:   r_asm_sop,
        eop:   r_asm_eop,
        empty: r_asm_empty,
        err:   r_asm_err
    };

    fix_st_out_reg u_out (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_move),
        .i_word     (w_word_in),
        .i_ready    (bus.ready_i),
        .o_valid    (w_valid),
        .o_word     (w_out),
        .o_can_load (w_can_load)
    );

    assign bus.readreq_o   = w_rdreq;
    assign bus.valid_o     = w_valid;
    assign bus.packet_o    = w_out.data;
    assign bus.start_pkt_o = w_out.sop;
    assign bus.end_pkt_o   = w_out.eop;
    assign bus.empty_o     = w_out.empty;
    assign bus.error_o     = w_out.err;
    assign bus.msg_count_o = r_msg_cnt;

endmodule

// File: tb/tb_fix_tx_packer.sv
// Directed bench: FIFO models feed two packers (default and 16-byte limit).
`timescale 1ns/1ps
module tb_fix_tx_packer;

    typedef struct {
        logic [63:0] pkt;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fix_tx_packer_if #(.CNT_W(16)) b0 ();
    fix_tx_packer_if #(.CNT_W(16)) b1 ();

    fix_tx_packer #(.CNT_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    fix_tx_packer #(.MAX_MSG_BYTES(16), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    logic [7:0] m0 [256];
    logic       e0 [256];
    logic [7:0] m1 [256];
    logic       e1 [256];
    int w0 = 0, r0 = 0, w1 = 0, r1 = 0;

    assign b0.rd_empty_i = (r0 == w0);
    assign b1.rd_empty_i = (r1 == w1);

    always @(posedge clk) begin
        if (b0.readreq_o) begin
            b0.rd_data_i <= m0[r0];
            b0.rd_eom_i  <= e0[r0];
            r0 <= r0 + 1;
        end
        if (b1.readreq_o) begin
            b1.rd_data_i <= m1[r1];
            b1.rd_eom_i  <= e1[r1];
            r1 <= r1 + 1;
        end
    end

    vec_t got0[$];
    vec_t got1[$];
    vec_t exp0[$];
    vec_t exp1[$];
    vec_t mv0, mv1;

    always @(negedge clk) begin
        if (rst && b0.valid_o && b0.ready_i) begin
            mv0.pkt = b0.packet_o;   mv0.sop = b0.start_pkt_o;
            mv0.eop = b0.end_pkt_o;  mv0.empty = b0.empty_o;
            mv0.err = b0.error_o;
            got0.push_back(mv0);
        end
        if (rst && b1.valid_o && b1.ready_i) begin
            mv1.pkt = b1.packet_o;   mv1.sop = b1.start_pkt_o;
            mv1.eop = b1.end_pkt_o;  mv1.empty = b1.empty_o;
            mv1.err = b1.error_o;
            got1.push_back(mv1);
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(int k, logic [7:0] d, logic eom);
        if (k == 0) begin
            m0[w0] = d; e0[w0] = eom; w0++;
        end else begin
            m1[w1] = d; e1[w1] = eom; w1++;
        end
    endtask

    task automatic msg(int k, logic [7:0] base, int len);
        for (int i = 0; i < len; i++)
            push(k, base + 8'(i), i == len - 1);
    endtask

    function automatic int nget(int k);
        return (k == 0) ? got0.size() : got1.size();
    endfunction

    task automatic wait_got(int k, int n, string name);
        int t;
        t = 0;
        while (nget(k) < n && t < 300) begin
            cyc(1);
            t++;
        end
        chk(name, 64'(nget(k)), 64'(n));
    endtask

    function automatic vec_t mk(logic [63:0] p, logic s, logic e,
                                logic [2:0] em, logic er);
        vec_t v;
        v.pkt = p; v.sop = s; v.eop = e; v.empty = em; v.err = er;
        return v;
    endfunction

    task automatic reset_chk(string tag);
        chk({tag, "_rdreq"}, 64'(b0.readreq_o), 64'd0);
        chk({tag, "_valid"}, 64'(b0.valid_o), 64'd0);
        chk({tag, "_pkt"},   b0.packet_o, 64'd0);
        chk({tag, "_flags"}, 64'({b0.start_pkt_o, b0.end_pkt_o,
                                  b0.error_o, b0.empty_o}), 64'd0);
        chk({tag, "_cnt"},   64'(b0.msg_count_o), 64'd0);
    endtask

    initial begin
        exp0.push_back(mk(64'h38393A3B3C3D3E3F, 1, 1, 0, 0));
        exp0.push_back(mk(64'h4041424344454647, 1, 0, 0, 0));
        exp0.push_back(mk(64'h48494A0000000000, 0, 1, 5, 0));
        exp0.push_back(mk(64'h5051525354555657, 1, 0, 0, 0));
        exp0.push_back(mk(64'h58595A5B5C5D5E5F, 0, 0, 0, 0));
        exp0.push_back(mk(64'h6061626300000000, 0, 1, 4, 0));
        exp0.push_back(mk(64'h7071727374000000, 1, 1, 3, 1));
        exp0.push_back(mk(64'h8081820000000000, 1, 1, 5, 0));
        exp0.push_back(mk(64'hA0A1A20000000000, 1, 1, 5, 0));
        exp1.push_back(mk(64'hB0B1B2B3B4B5B6B7, 1, 0, 0, 0));
        exp1.push_back(mk(64'hB8B9BABBBCBDBEBF, 0, 1, 0, 1));
        exp1.push_back(mk(64'hD0D1D2D300000000, 1, 1, 4, 0));

        b0.ready_i = 1'b1; b0.rd_error_i = 1'b0;
        b1.ready_i = 1'b1; b1.rd_error_i = 1'b0;
        cyc(3);
        reset_chk("rst0");
        rst = 1'b1;
        cyc(2);

        msg(0, 8'h38, 8);
        wait_got(0, 1, "t1_words");
        chk("t1_cnt", 64'(b0.msg_count_o), 64'd1);

        msg(0, 8'h40, 11);
        wait_got(0, 3, "t2_words");
        chk("t2_cnt", 64'(b0.msg_count_o), 64'd2);

        b0.ready_i = 1'b0;
        msg(0, 8'h50, 20);
        cyc(30);
        chk("stall_rdreq", 64'(b0.readreq_o), 64'd0);
        chk("stall_valid", 64'(b0.valid_o), 64'd1);
        chk("stall_pkt", b0.packet_o, 64'h5051525354555657);
        chk("stall_sop", 64'(b0.start_pkt_o), 64'd1);
        chk("stall_reads", 64'(r0), 64'd36);
        b0.ready_i = 1'b1;
        wait_got(0, 6, "t3_words");
        chk("t3_cnt", 64'(b0.msg_count_o), 64'd3);

        push(0, 8'h70, 0);
        push(0, 8'h71, 0);
        cyc(6);
        b0.rd_error_i = 1'b1;
        cyc(1);
        b0.rd_error_i = 1'b0;
        push(0, 8'h72, 0);
        push(0, 8'h73, 0);
        push(0, 8'h74, 1);
        wait_got(0, 7, "t4_words");
        msg(0, 8'h80, 3);
        wait_got(0, 8, "t4b_words");
        chk("t4_cnt", 64'(b0.msg_count_o), 64'd5);

        msg(1, 8'hB0, 24);
        wait_got(1, 2, "t5_words");
        cyc(10);
        chk("t5_reads", 64'(r1), 64'd24);
        chk("t5_nodrop_out", 64'(b1.valid_o), 64'd0);
        msg(1, 8'hD0, 4);
        wait_got(1, 3, "t5b_words");
        chk("t5_cnt", 64'(b1.msg_count_o), 64'd2);

        for (int i = 0; i < 5; i++)
            push(0, 8'h90 + 8'(i), 0);
        cyc(10);
        chk("t6_reads", 64'(r0), 64'd52);
        chk("t6_noword", 64'(b0.valid_o), 64'd0);
        rst = 1'b0;
        #1;
        reset_chk("rst1");
        msg(0, 8'hA0, 3);
        cyc(2);
        chk("rst_hold_rdreq", 64'(b0.readreq_o), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rel_rdreq", 64'(b0.readreq_o), 64'd0);
        wait_got(0, 9, "t6_words");
        chk("t6_cnt", 64'(b0.msg_count_o), 64'd1);
        cyc(5);

        chk("n_words0", 64'(got0.size()), 64'(exp0.size()));
        chk("n_words1", 64'(got1.size()), 64'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            chk($sformatf("w0_%0d_pkt", i), got0[i].pkt, exp0[i].pkt);
            chk($sformatf("w0_%0d_flags", i),
                64'({got0[i].sop, got0[i].eop, got0[i].err}),
                64'({exp0[i].sop, exp0[i].eop, exp0[i].err}));
            if (exp0[i].eop)
                chk($sformatf("w0_%0d_empty", i),
                    64'(got0[i].empty), 64'(exp0[i].empty));
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            chk($sformatf("w1_%0d_pkt", i), got1[i].pkt, exp1[i].pkt);
            chk($sformatf("w1_%0d_flags", i),
                64'({got1[i].sop, got1[i].eop, got1[i].err}),
                64'({exp1[i].sop, exp1[i].eop, exp1[i].err}));
            if (exp1[i].eop)
                chk($sformatf("w1_%0d_empty", i),
                    64'(got1[i].empty), 64'(exp1[i].empty));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
